// File: rtl/qam4_mapper_upsampler_if.sv
// Symbol-in / sample-out bus between the SPC stage, the 4-QAM mapper-upsampler
// and the downstream pulse-shaping filter.
interface qam4_mapper_upsampler_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    logic [1:0]              din;
    logic                    din_valid;
    logic signed [W-1:0]     i_out;
    logic signed [W-1:0]     q_out;
    logic                    dout_valid;
    logic                    sym_start;
    logic [CNT_W-1:0]        sym_cnt;
    logic                    overrun;

    // Producer side: drives symbols, observes samples and status.
    modport master (
        output din, din_valid,
        input  i_out, q_out, dout_valid, sym_start, sym_cnt, overrun
    );

    // Mapper side: consumes symbols, produces samples and status.
    modport slave (
        input  din, din_valid,
        output i_out, q_out, dout_valid, sym_start, sym_cnt, overrun
    );
endinterface

// File: rtl/qam4_mapper_upsampler.sv
// Gray-mapped 4-QAM symbol mapper followed by an OSR-times upsampler.
// Each accepted symbol becomes a burst of OSR registered I/Q samples. The
// first sample carries the mapped value; the rest are zero or a repeat.
module qam4_mapper_upsampler #(
    parameter int W          = 8,
    parameter int AMP        = 91,
    parameter int OSR        = 2,
    parameter bit ZERO_STUFF = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    qam4_mapper_upsampler_if.slave      bus
);
    localparam int                PH_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [PH_W-1:0]   LAST = PH_W'(OSR - 1);
    localparam logic signed [W-1:0] POS = W'(AMP);
    localparam logic signed [W-1:0] NEG = W'(-AMP);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                 state_q, state_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic signed [W-1:0]    i_q, i_d;
    logic signed [W-1:0]    q_q, q_d;
    logic signed [W-1:0]    hold_i_q, hold_i_d;
    logic signed [W-1:0]    hold_q_q, hold_q_d;
    logic                   valid_q, valid_d;
    logic                   start_q, start_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovr_q, ovr_d;

    // Per-lane Gray mapping: lane 1 is I (din[1]), lane 0 is Q (din[0]).
    logic signed [W-1:0]    map_val [2];
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_map
            assign map_val[gi] = bus.din[gi] ? NEG : POS;
        end
    endgenerate

    // A new symbol may start only when idle or on the last sample of a burst.
    logic accept;
    assign accept = en && bus.din_valid && ((state_q == IDLE) || (phase_q == LAST));

    // Next-state and next-output logic; idle/aborted outputs default to zero.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        i_d      = '0;
        q_d      = '0;
        valid_d  = 1'b0;
        start_d  = 1'b0;
        hold_i_d = hold_i_q;
        hold_q_d = hold_q_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;

        if (!en) begin
            state_d = IDLE;
            phase_d = '0;
        end else if (accept) begin
            state_d  = EMIT;
            phase_d  = '0;
            hold_i_d = map_val[1];
            hold_q_d = map_val[0];
            i_d      = map_val[1];
            q_d      = map_val[0];
            valid_d  = 1'b1;
            start_d  = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
        end else if (state_q == EMIT) begin
            // A symbol arriving mid-burst is dropped but remembered.
            if (bus.din_valid) begin
                ovr_d = 1'b1;
            end
            if (phase_q == LAST) begin
                state_d = IDLE;
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
                valid_d = 1'b1;
                i_d     = ZERO_STUFF ? '0 : hold_i_q;
                q_d     = ZERO_STUFF ? '0 : hold_q_q;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            i_q      <= '0;
            q_q      <= '0;
            hold_i_q <= '0;
            hold_q_q <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            i_q      <= i_d;
            q_q      <= q_d;
            hold_i_q <= hold_i_d;
            hold_q_q <= hold_q_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.i_out      = i_q;
    assign bus.q_out      = q_q;
    assign bus.dout_valid = valid_q;
    assign bus.sym_start  = start_q;
    assign bus.sym_cnt    = cnt_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_qam4_mapper_upsampler.sv
// Bench for qam4_mapper_upsampler: three instances (OSR=2 zero-stuff,
// OSR=4 hold, OSR=4 zero-stuff) checked every cycle against a burst model,
// plus literal expectations for each directed scenario.
module tb_qam4_mapper_upsampler;
    localparam int W     = 8;
    localparam int AMP   = 91;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   [3];
    logic       en_s    [3];
    logic [1:0] drv_din [3];
    logic       drv_dv  [3];

    qam4_mapper_upsampler_if #(.W(W), .CNT_W(CNT_W)) ifa ();
    qam4_mapper_upsampler_if #(.W(W), .CNT_W(CNT_W)) ifb ();
    qam4_mapper_upsampler_if #(.W(W), .CNT_W(CNT_W)) ifc ();

    assign ifa.din = drv_din[0];  assign ifa.din_valid = drv_dv[0];
    assign ifb.din = drv_din[1];  assign ifb.din_valid = drv_dv[1];
    assign ifc.din = drv_din[2];  assign ifc.din_valid = drv_dv[2];

    qam4_mapper_upsampler #(.W(W), .AMP(AMP), .OSR(2), .ZERO_STUFF(1'b1), .CNT_W(CNT_W))
        dut_a (.clk(clk), .rst(rst_s[0]), .en(en_s[0]), .bus(ifa.slave));
    qam4_mapper_upsampler #(.W(W), .AMP(AMP), .OSR(4), .ZERO_STUFF(1'b0), .CNT_W(CNT_W))
        dut_b (.clk(clk), .rst(rst_s[1]), .en(en_s[1]), .bus(ifb.slave));
    qam4_mapper_upsampler #(.W(W), .AMP(AMP), .OSR(4), .ZERO_STUFF(1'b1), .CNT_W(CNT_W))
        dut_c (.clk(clk), .rst(rst_s[2]), .en(en_s[2]), .bus(ifc.slave));

    logic signed [W-1:0] act_i [3];
    logic signed [W-1:0] act_q [3];
    logic                act_v [3];
    logic                act_s [3];
    logic [CNT_W-1:0]    act_c [3];
    logic                act_o [3];
    assign act_i[0] = ifa.i_out; assign act_q[0] = ifa.q_out; assign act_v[0] = ifa.dout_valid;
    assign act_s[0] = ifa.sym_start; assign act_c[0] = ifa.sym_cnt; assign act_o[0] = ifa.overrun;
    assign act_i[1] = ifb.i_out; assign act_q[1] = ifb.q_out; assign act_v[1] = ifb.dout_valid;
    assign act_s[1] = ifb.sym_start; assign act_c[1] = ifb.sym_cnt; assign act_o[1] = ifb.overrun;
    assign act_i[2] = ifc.i_out; assign act_q[2] = ifc.q_out; assign act_v[2] = ifc.dout_valid;
    assign act_s[2] = ifc.sym_start; assign act_c[2] = ifc.sym_cnt; assign act_o[2] = ifc.overrun;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int osr_of(input int m);
        return (m == 0) ? 2 : 4;
    endfunction
    function automatic bit zs_of(input int m);
        return (m != 1);
    endfunction
    function automatic int amp_of(input logic b);
        return b ? -AMP : AMP;
    endfunction

    // Burst model: an accepted symbol owns the next OSR output cycles.
    bit m_init [3];
    int m_rem  [3];
    int m_hi   [3];
    int m_hq   [3];
    int m_cnt  [3];
    bit m_ovr  [3];
    int e_i    [3];
    int e_q    [3];
    bit e_v    [3];
    bit e_s    [3];

    initial begin
        for (int m = 0; m < 3; m++) begin
            m_init[m] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int m = 0; m < 3; m++) begin
            bit can_take;
            if (rst_s[m]) begin
                m_init[m] = 1'b1; m_rem[m] = 0; m_cnt[m] = 0; m_ovr[m] = 1'b0;
                m_hi[m] = 0; m_hq[m] = 0;
                e_i[m] = 0; e_q[m] = 0; e_v[m] = 1'b0; e_s[m] = 1'b0;
            end else if (!en_s[m]) begin
                m_rem[m] = 0;
                e_i[m] = 0; e_q[m] = 0; e_v[m] = 1'b0; e_s[m] = 1'b0;
            end else begin
                can_take = !e_v[m] || (m_rem[m] == 0);
                if (drv_dv[m] && can_take) begin
                    m_hi[m]  = amp_of(drv_din[m][1]);
                    m_hq[m]  = amp_of(drv_din[m][0]);
                    m_cnt[m] = (m_cnt[m] + 1) % 65536;
                    m_rem[m] = osr_of(m) - 1;
                    e_i[m] = m_hi[m]; e_q[m] = m_hq[m]; e_v[m] = 1'b1; e_s[m] = 1'b1;
                end else begin
                    if (drv_dv[m]) m_ovr[m] = 1'b1;
                    if (m_rem[m] > 0) begin
                        m_rem[m]--;
                        e_v[m] = 1'b1; e_s[m] = 1'b0;
                        e_i[m] = zs_of(m) ? 0 : m_hi[m];
                        e_q[m] = zs_of(m) ? 0 : m_hq[m];
                    end else begin
                        e_i[m] = 0; e_q[m] = 0; e_v[m] = 1'b0; e_s[m] = 1'b0;
                    end
                end
            end
        end
    end

    // Golden symbols of the throughput run, in SPC order.
    int gold_i [$];
    int gold_q [$];
    bit gold_en = 1'b0;
    int vcount  = 0;

    // Single compare process: every instance, every cycle, away from the edge.
    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (m_init[m]) begin
                check($sformatf("dut%0d i_out", m), int'(act_i[m]), e_i[m]);
                check($sformatf("dut%0d q_out", m), int'(act_q[m]), e_q[m]);
                check($sformatf("dut%0d dout_valid", m), int'(act_v[m]), int'(e_v[m]));
                check($sformatf("dut%0d sym_start", m), int'(act_s[m]), int'(e_s[m]));
                check($sformatf("dut%0d sym_cnt", m), int'(act_c[m]), m_cnt[m]);
                check($sformatf("dut%0d overrun", m), int'(act_o[m]), int'(m_ovr[m]));
            end
        end
        if (gold_en) begin
            if (act_v[0] === 1'b1) vcount++;
            if (act_s[0] === 1'b1) begin
                if (gold_i.size() == 0) begin
                    check("prbs golden queue underflow", 1, 0);
                end else begin
                    check("prbs phase0 i", int'(act_i[0]), gold_i.pop_front());
                    check("prbs phase0 q", int'(act_q[0]), gold_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int map_i [4] = '{91, 91, -91, -91};
    int map_q [4] = '{91, -91, 91, -91};

    initial begin
        logic [6:0] lfsr;
        logic [1:0] sym;
        logic       b0, b1;

        for (int m = 0; m < 3; m++) begin
            rst_s[m] = 1'b1; en_s[m] = 1'b1; drv_din[m] = 2'b00; drv_dv[m] = 1'b0;
        end

        // Reset with random symbol traffic.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int m = 0; m < 3; m++) begin
                drv_din[m] = 2'($urandom_range(0, 3));
                drv_dv[m]  = 1'($urandom_range(0, 1));
            end
            if (c > 0) check("reset dout_valid", int'(act_v[0]) + int'(act_v[2]), 0);
        end
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            rst_s[m] = 1'b0; drv_dv[m] = 1'b0;
        end
        tick(1);
        check("after reset i_out", int'(act_i[0]), 0);
        check("after reset sym_cnt", int'(act_c[1]), 0);
        check("after reset overrun", int'(act_o[2]), 0);

        // Mapping on OSR=2 zero-stuffed instance.
        for (int s = 0; s < 4; s++) begin
            drv_din[0] = 2'(s); drv_dv[0] = 1'b1;
            tick(1);
            drv_dv[0] = 1'b0;
            check($sformatf("map %0d phase0 i", s), int'(act_i[0]), map_i[s]);
            check($sformatf("map %0d phase0 q", s), int'(act_q[0]), map_q[s]);
            tick(1);
            check($sformatf("map %0d phase1 i", s), int'(act_i[0]), 0);
            check($sformatf("map %0d phase1 valid", s), int'(act_v[0]), 1);
        end
        check("map sym_cnt", int'(act_c[0]), 4);
        tick(1);
        check("map idle valid", int'(act_v[0]), 0);

        // Hold mode: one symbol 10 on OSR=4 repeat instance.
        drv_din[1] = 2'b10; drv_dv[1] = 1'b1;
        tick(1);
        drv_dv[1] = 1'b0;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("hold p%0d i", p), int'(act_i[1]), -91);
            check($sformatf("hold p%0d q", p), int'(act_q[1]), 91);
            check($sformatf("hold p%0d start", p), int'(act_s[1]), (p == 0) ? 1 : 0);
            tick(1);
        end
        check("hold end valid", int'(act_v[1]), 0);

        // Overrun: back-to-back strobes on OSR=4.
        drv_din[2] = 2'b01; drv_dv[2] = 1'b1;
        tick(1);
        drv_din[2] = 2'b11;
        check("ovr first i", int'(act_i[2]), 91);
        tick(1);
        drv_dv[2] = 1'b0;
        check("ovr flag", int'(act_o[2]), 1);
        check("ovr burst continues", int'(act_v[2]), 1);
        tick(3);
        check("ovr sym_cnt", int'(act_c[2]), 1);
        check("ovr burst done", int'(act_v[2]), 0);

        // Abort by dropping en at phase 1.
        drv_din[2] = 2'b00; drv_dv[2] = 1'b1;
        tick(1);
        drv_dv[2] = 1'b0;
        tick(1);
        en_s[2] = 1'b0;
        tick(1);
        check("abort valid", int'(act_v[2]), 0);
        check("abort i", int'(act_i[2]), 0);
        check("abort sticky ovr", int'(act_o[2]), 1);
        check("abort sym_cnt", int'(act_c[2]), 2);
        en_s[2] = 1'b1;
        tick(1);

        // Reset at phase 2.
        drv_din[2] = 2'b11; drv_dv[2] = 1'b1;
        tick(1);
        drv_dv[2] = 1'b0;
        tick(2);
        rst_s[2] = 1'b1;
        tick(1);
        rst_s[2] = 1'b0;
        check("midrst sym_cnt", int'(act_c[2]), 0);
        check("midrst overrun", int'(act_o[2]), 0);
        check("midrst valid", int'(act_v[2]), 0);

        // Throughput: PRBS7 bits paired as SPC would, one symbol per 2 clocks.
        lfsr = 7'h5A;
        vcount = 0;
        gold_en = 1'b1;
        for (int k = 0; k < 512; k++) begin
            b0 = lfsr[6] ^ lfsr[5]; lfsr = {lfsr[5:0], b0};
            b1 = lfsr[6] ^ lfsr[5]; lfsr = {lfsr[5:0], b1};
            sym = {b0, b1};
            gold_i.push_back(amp_of(b0));
            gold_q.push_back(amp_of(b1));
            drv_din[0] = sym; drv_dv[0] = 1'b1;
            tick(1);
            drv_dv[0] = 1'b0;
            tick(1);
        end
        tick(3);
        gold_en = 1'b0;
        check("prbs valid samples", vcount, 1024);
        check("prbs sym_cnt", int'(act_c[0]), 516);
        check("prbs overrun", int'(act_o[0]), 0);
        check("prbs golden left", gold_i.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
